wvb_wr_addr_ctrl: RTL

Write-side address controller for the mDOM waveform buffer. It writes ADC samples into the circular sample RAM and captures a pre-trigger/post-trigger window around each trigger. It pushes one header per waveform (start/stop address, LTC, trigger source) into the header FIFO. Released space is reclaimed when the read side reports a finished waveform, and committed-but-unread samples are never overwritten.

---
 rtl/wvb_wr_pkg.sv | 29 ++
 rtl/wvb_wr_addr_ctrl_if.sv | 41 ++++
 rtl/wvb_wr_hdr_fan_in.sv | 27 ++
 rtl/wvb_wr_addr_ctrl.sv | 152 +++++++++++++++
 4 files changed

// File: rtl/wvb_wr_pkg.sv
// Shared definitions for the waveform-buffer write side: FSM encoding and header field layout.
// The read-side fan-out uses the same offsets to unpack hdr_data.
package wvb_wr_pkg;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_RECORD = 1'b1
  } wr_state_e;

  // Header layout, LSB first: trunc, trig_src, stop_addr, start_addr, evt_ltc
  localparam int unsigned HDR_TRUNC_LSB = 0;
  localparam int unsigned HDR_TRUNC_W   = 1;
  localparam int unsigned HDR_SRC_LSB   = 1;
  localparam int unsigned HDR_SRC_W     = 2;
  localparam int unsigned HDR_STOP_LSB  = 3;

  function automatic int unsigned hdr_start_lsb(input int unsigned adr_w);
    return HDR_STOP_LSB + adr_w;
  endfunction

  function automatic int unsigned hdr_ltc_lsb(input int unsigned adr_w);
    return HDR_STOP_LSB + 2 * adr_w;
  endfunction

  function automatic int unsigned hdr_width(input int unsigned adr_w, input int unsigned ltc_w);
    return hdr_ltc_lsb(adr_w) + ltc_w;
  endfunction

endpackage

// File: rtl/wvb_wr_addr_ctrl_if.sv
// Sample, trigger, RAM-write, header and release signals of the waveform-buffer write controller.
// master is the controller side, slave is the surrounding datapath.
interface wvb_wr_addr_ctrl_if #(
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_LTC_WIDTH  = 48,
  parameter int unsigned P_HDR_WIDTH  = P_LTC_WIDTH + 2 * P_ADR_WIDTH + 3
);
  logic [P_DATA_WIDTH-1:0] din;
  logic                    din_valid;
  logic                    trig;
  logic [1:0]              trig_src;
  logic [P_LTC_WIDTH-1:0]  ltc_in;
  logic [P_ADR_WIDTH-1:0]  pre_conf;
  logic [P_ADR_WIDTH-1:0]  post_conf;
  logic                    hdr_full;
  logic                    rel_valid;
  logic [P_ADR_WIDTH-1:0]  rel_stop_addr;
  logic [P_DATA_WIDTH-1:0] wvb_wr_data;
  logic [P_ADR_WIDTH-1:0]  wvb_wr_addr;
  logic                    wvb_wren;
  logic [P_HDR_WIDTH-1:0]  hdr_data;
  logic                    hdr_wrreq;
  logic                    buf_full;
  logic [P_ADR_WIDTH-1:0]  n_wvf;
  logic [15:0]             drop_cnt;

  modport master (
    input  din, din_valid, trig, trig_src, ltc_in, pre_conf, post_conf,
           hdr_full, rel_valid, rel_stop_addr,
    output wvb_wr_data, wvb_wr_addr, wvb_wren, hdr_data, hdr_wrreq,
           buf_full, n_wvf, drop_cnt
  );

  modport slave (
    output din, din_valid, trig, trig_src, ltc_in, pre_conf, post_conf,
           hdr_full, rel_valid, rel_stop_addr,
    input  wvb_wr_data, wvb_wr_addr, wvb_wren, hdr_data, hdr_wrreq,
           buf_full, n_wvf, drop_cnt
  );
endinterface

// File: rtl/wvb_wr_hdr_fan_in.sv
// Packs the per-waveform header fields into the header FIFO word using the shared layout.
module wvb_wr_hdr_fan_in
  import wvb_wr_pkg::*;
#(
  parameter int unsigned P_ADR_WIDTH = 12,
  parameter int unsigned P_LTC_WIDTH = 48,
  parameter int unsigned P_HDR_WIDTH = P_LTC_WIDTH + 2 * P_ADR_WIDTH + 3
) (
  input  logic [P_LTC_WIDTH-1:0] evt_ltc,
  input  logic [P_ADR_WIDTH-1:0] start_addr,
  input  logic [P_ADR_WIDTH-1:0] stop_addr,
  input  logic [1:0]             trig_src,
  input  logic                   trunc,
  output logic [P_HDR_WIDTH-1:0] hdr_data_c
);
  localparam int unsigned START_LSB = hdr_start_lsb(P_ADR_WIDTH);
  localparam int unsigned LTC_LSB   = hdr_ltc_lsb(P_ADR_WIDTH);

  always_comb begin
    hdr_data_c = '0;
    hdr_data_c[HDR_TRUNC_LSB +: HDR_TRUNC_W] = trunc;
    hdr_data_c[HDR_SRC_LSB +: HDR_SRC_W]     = trig_src;
    hdr_data_c[HDR_STOP_LSB +: P_ADR_WIDTH]  = stop_addr;
    hdr_data_c[START_LSB +: P_ADR_WIDTH]     = start_addr;
    hdr_data_c[LTC_LSB +: P_LTC_WIDTH]       = evt_ltc;
  end
endmodule

// File: rtl/wvb_wr_addr_ctrl.sv
// Write-side address controller: circular sample RAM writes, pre/post-trigger window capture, header push.
// Optional WVB_WR_DROP_CNT_EN enables the saturating dropped-trigger counter; otherwise drop_cnt is 0.
module wvb_wr_addr_ctrl
  import wvb_wr_pkg::*;
#(
  parameter int unsigned P_ADR_WIDTH  = 12,
  parameter int unsigned P_DATA_WIDTH = 22,
  parameter int unsigned P_LTC_WIDTH  = 48,
  parameter int unsigned P_HDR_WIDTH  = P_LTC_WIDTH + 2 * P_ADR_WIDTH + 3
) (
  input  logic               clk,
  input  logic               rst,
  wvb_wr_addr_ctrl_if.master bus
);
  localparam int unsigned AW = P_ADR_WIDTH;

  wr_state_e              state, state_nxt;
  logic [AW-1:0]          wr_ptr, rd_bound, fresh_cnt, rem_cnt, start_q, n_wvf;
  logic [P_LTC_WIDTH-1:0] ltc_q;
  logic [1:0]             src_q;

  logic                   blocked_c, wr_c, accept_c, window_wr_c, commit_c, trunc_c, rel_c;
  logic                   cnt_done_c, next_blk_c;
  logic [AW-1:0]          pre_eff_c, post_eff_c, rem_cur_c, start_c, next_ptr_c;
  logic [AW-1:0]          wr_ptr_nxt, rd_bound_nxt, n_wvf_nxt;
  logic [P_LTC_WIDTH-1:0] ltc_c;
  logic [1:0]             src_c;
  logic [P_HDR_WIDTH-1:0] hdr_c;

  // Next-state, window bookkeeping and commit decision
  always_comb begin
    state_nxt   = state;
    blocked_c   = (n_wvf != '0) && (wr_ptr == rd_bound);
    wr_c        = bus.din_valid && !blocked_c;
    accept_c    = 1'b0;
    window_wr_c = 1'b0;
    rem_cur_c   = rem_cnt;
    start_c     = start_q;
    ltc_c       = ltc_q;
    src_c       = src_q;
    pre_eff_c   = (bus.pre_conf < fresh_cnt) ? bus.pre_conf : fresh_cnt;
    post_eff_c  = (bus.post_conf == '0) ? AW'(1) : bus.post_conf;
    next_ptr_c  = wr_ptr + AW'(1);

    case (state)
      ST_IDLE: begin
        if (bus.trig && wr_c && !bus.hdr_full) begin
          accept_c    = 1'b1;
          window_wr_c = 1'b1;
          rem_cur_c   = post_eff_c;
          start_c     = wr_ptr - pre_eff_c;
          ltc_c       = bus.ltc_in;
          src_c       = bus.trig_src;
          state_nxt   = ST_RECORD;
        end
      end
      ST_RECORD: window_wr_c = wr_c;
      default:   state_nxt   = ST_IDLE;
    endcase

    // Close the window on its last sample, or early when the following write would block
    cnt_done_c = (rem_cur_c == AW'(1));
    next_blk_c = (n_wvf != '0) && (next_ptr_c == rd_bound);
    commit_c   = window_wr_c && (cnt_done_c || next_blk_c);
    trunc_c    = !cnt_done_c;
    if (commit_c) state_nxt = ST_IDLE;

    rel_c        = bus.rel_valid && (n_wvf != '0);
    wr_ptr_nxt   = wr_c ? next_ptr_c : wr_ptr;
    rd_bound_nxt = rel_c ? bus.rel_stop_addr + AW'(1) : rd_bound;
    case ({commit_c, rel_c})
      2'b10:   n_wvf_nxt = n_wvf + AW'(1);
      2'b01:   n_wvf_nxt = n_wvf - AW'(1);
      default: n_wvf_nxt = n_wvf;
    endcase
  end

  wvb_wr_hdr_fan_in #(
    .P_ADR_WIDTH (P_ADR_WIDTH),
    .P_LTC_WIDTH (P_LTC_WIDTH),
    .P_HDR_WIDTH (P_HDR_WIDTH)
  ) u_hdr_fan_in (
    .evt_ltc    (ltc_c),
    .start_addr (start_c),
    .stop_addr  (wr_ptr),
    .trig_src   (src_c),
    .trunc      (trunc_c),
    .hdr_data_c (hdr_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= ST_IDLE;
      wr_ptr          <= '0;
      rd_bound        <= '0;
      fresh_cnt       <= '0;
      rem_cnt         <= '0;
      start_q         <= '0;
      ltc_q           <= '0;
      src_q           <= '0;
      n_wvf           <= '0;
      bus.n_wvf       <= '0;
      bus.wvb_wren    <= 1'b0;
      bus.wvb_wr_addr <= '0;
      bus.wvb_wr_data <= '0;
      bus.hdr_wrreq   <= 1'b0;
      bus.hdr_data    <= '0;
      bus.buf_full    <= 1'b0;
    end else begin
      state     <= state_nxt;
      wr_ptr    <= wr_ptr_nxt;
      rd_bound  <= rd_bound_nxt;
      n_wvf     <= n_wvf_nxt;
      bus.n_wvf <= n_wvf_nxt;
      if (accept_c) begin
        start_q <= start_c;
        ltc_q   <= ltc_c;
        src_q   <= src_c;
      end
      if (window_wr_c) rem_cnt <= rem_cur_c - AW'(1);
      if (commit_c || blocked_c) begin
        fresh_cnt <= '0;
      end else if (state == ST_IDLE && wr_c && fresh_cnt != '1) begin
        fresh_cnt <= fresh_cnt + AW'(1);
      end
      bus.wvb_wren <= wr_c;
      if (wr_c) begin
        bus.wvb_wr_addr <= wr_ptr;
        bus.wvb_wr_data <= bus.din;
      end
      bus.hdr_wrreq <= commit_c;
      if (commit_c) bus.hdr_data <= hdr_c;
      bus.buf_full <= (n_wvf_nxt != '0) && (wr_ptr_nxt == rd_bound_nxt);
    end
  end

`ifdef WVB_WR_DROP_CNT_EN
  logic drop_c;
  assign drop_c = bus.trig && bus.din_valid && !accept_c;

  always_ff @(posedge clk) begin
    if (rst) begin
      bus.drop_cnt <= '0;
    end else if (drop_c && bus.drop_cnt != 16'hFFFF) begin
      bus.drop_cnt <= bus.drop_cnt + 16'd1;
    end
  end
`else
  assign bus.drop_cnt = '0;
`endif

endmodule
